// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with wrap-bit pointers, occupancy count and sticky error flags
// Ports: clk, clrn (async active-low reset), write/read requests, data_in, data_out (head of queue),
//   ready (non-empty), full, almost_full (count >= AF_TH), almost_empty (count <= AE_TH),
//   count (0..D), overflow/underflow (sticky rejected push/pop).
// Build option: define PARAM_FIFO_REG_OUT_EN for a registered data_out loaded on each pop;
//   left undefined, data_out shows the head entry combinationally.
module param_fifo #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int AF_TH = 6,
  parameter int AE_TH = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          write,
  input  logic          read,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          ready,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);
  localparam int D = 1 << AW;
  logic [DW-1:0] mem [D];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign ready = wr_ptr != rd_ptr;
  // pointers equal except for the wrap bit means every entry is occupied
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign almost_full = int'(count) >= AF_TH;
  assign almost_empty = int'(count) <= AE_TH;
  // a full FIFO still takes a push when the same edge frees an entry
  assign push = write && (!full || read);
  assign pop = read && ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= data_in;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      overflow <= (write && full && !read) || (overflow && !pop);
      underflow <= (read && !ready) || (underflow && !push);
    end
`ifdef PARAM_FIFO_REG_OUT_EN
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) data_out <= '0;
    else if (pop) data_out <= mem[rd_ptr[AW-1:0]];
`else
  assign data_out = mem[rd_ptr[AW-1:0]];
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo (DW=8, AW=3, AF_TH=6, AE_TH=1)
module tb_param_fifo;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic write = 1'b0;
  logic read = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic ready, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int n = 0;
  int errs = 0;

  param_fifo #(.DW(8), .AW(3), .AF_TH(6), .AE_TH(1)) dut (
    .clk(clk), .clrn(clrn), .write(write), .read(read), .data_in(data_in),
    .data_out(data_out), .ready(ready), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    write = w;
    read = r;
    data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0;
    read = 1'b0;
  endtask

  // pop one word and check it arrives on data_out with the mode's latency
  task automatic pop_chk(input string tag, input logic [7:0] exp, input logic w, input logic [7:0] d);
`ifdef PARAM_FIFO_REG_OUT_EN
    step(w, 1'b1, d);
    chk(tag, data_out, exp);
`else
    chk(tag, data_out, exp);
    step(w, 1'b1, d);
`endif
  endtask

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'((i + 1) * 17));
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 6);
      chk("fill_ae", almost_empty, (i + 1) <= 1);
      chk("fill_full", full, i == 7);
`ifndef PARAM_FIFO_REG_OUT_EN
      chk("fill_head", data_out, 8'h11);
`endif
    end
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    step(1'b1, 1'b1, 8'h99);
    chk("rw_full_count", count, 8);
    chk("rw_full_ovf", overflow, 0);
    chk("rw_full_full", full, 1);
    for (int i = 0; i < 8; i++)
      pop_chk("drain_data", i == 7 ? 8'h99 : 8'((i + 2) * 17), 1'b0, 8'h00);
    chk("drain_count", count, 0);
    chk("drain_ready", ready, 0);
    chk("drain_ae", almost_empty, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("unf_set", underflow, 1);
    chk("unf_ready", ready, 0);
    chk("unf_count", count, 0);
    step(1'b1, 1'b0, 8'h5A);
    chk("unf_clr", underflow, 0);
    chk("push5a_ready", ready, 1);
    chk("push5a_count", count, 1);
`ifndef PARAM_FIFO_REG_OUT_EN
    chk("push5a_data", data_out, 8'h5A);
`endif
    pop_chk("pop5a_data", 8'h5A, 1'b0, 8'h00);
    chk("pop5a_count", count, 0);
    step(1'b1, 1'b0, 8'hA5);
    pop_chk("popa5_data", 8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    chk("stream_prefill", count, 3);
    for (int i = 0; i < 17; i++) begin
      pop_chk("stream_data", 8'(i), 1'b1, 8'(i + 3));
      chk("stream_count", count, 3);
      chk("stream_flags", {full, overflow, underflow, almost_empty, almost_full}, 0);
    end
    for (int i = 17; i < 20; i++) pop_chk("stream_tail", 8'(i), 1'b0, 8'h00);
    chk("stream_end_count", count, 0);
    chk("stream_end_flags", {overflow, underflow}, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_rst_count", count, 5);
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_ae", almost_empty, 1);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h77);
    chk("post_rst_count", count, 1);
    pop_chk("post_rst_data", 8'h77, 1'b0, 8'h00);
    chk("post_rst_empty", ready, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
